// File: rtl/vec_instr_queue_pkg.sv
// Shared opcode constants and instruction classification for the vector issue queue.
package vec_instr_queue_pkg;

  localparam int VQ_DEPTH = 4;

  localparam logic [6:0] OPC_OPV    = 7'b1010111;
  localparam logic [6:0] OPC_VLOAD  = 7'b0000111;
  localparam logic [6:0] OPC_VSTORE = 7'b0100111;

  localparam logic [2:0] F3_OPIVX = 3'b100;
  localparam logic [2:0] F3_OPMVX = 3'b110;
  localparam logic [2:0] F3_OPCFG = 3'b111;

  typedef enum logic [1:0] {
    VCLS_NONE   = 2'd0,
    VCLS_VEC    = 2'd1,
    VCLS_SCALAR = 2'd2
  } vec_class_e;

  // Vector loads/stores always carry a scalar base address in rs1.
  function automatic vec_class_e classify(input logic [6:0] opc, input logic [2:0] f3);
    vec_class_e cls;
    cls = VCLS_NONE;
    if (opc == OPC_VLOAD || opc == OPC_VSTORE) begin
      cls = VCLS_SCALAR;
    end else if (opc == OPC_OPV) begin
      if (f3 == F3_OPIVX || f3 == F3_OPMVX || f3 == F3_OPCFG)
        cls = VCLS_SCALAR;
      else
        cls = VCLS_VEC;
    end
    return cls;
  endfunction

endpackage

// File: rtl/vq_fifo.sv
// Synchronous show-ahead FIFO; flush clears occupancy and has priority over reads and writes.
module vq_fifo
  import vec_instr_queue_pkg::*;
#(
  parameter int DEPTH     = VQ_DEPTH,
  parameter int ADDR_BITS = 2,
  parameter int DATA_W    = 64
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 rd_en,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   count
);

  localparam logic [ADDR_BITS:0] FULL_CNT = DEPTH[ADDR_BITS:0];

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   cnt;
  logic                 wr_ok;
  logic                 rd_ok;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign wr_ok = wr_en & ~full & ~flush;
  assign rd_ok = rd_en & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (!nrst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; an empty queue masks whatever it holds.
  always_ff @(posedge clk) begin
    if (nrst && wr_ok)
      mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/vec_instr_queue.sv
// Vector issue queue: classifies core instructions, attaches the scalar operand and buffers them for the vector unit.
module vec_instr_queue
  import vec_instr_queue_pkg::*;
#(
  parameter int DEPTH        = VQ_DEPTH,
  parameter int ADDR_BITS    = 2,
  parameter int WORD_WIDTH   = 32,
  parameter int REGFILE_BITS = 5
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    instr_valid,
  input  logic [WORD_WIDTH-1:0]   instr,
  output logic                    instr_ready,
  output logic [REGFILE_BITS-1:0] v_rd_xreg_addr,
  input  logic [WORD_WIDTH-1:0]   xreg_out,
  input  logic                    flush,
  output logic                    vq_valid,
  output logic [WORD_WIDTH-1:0]   vq_instr,
  output logic [WORD_WIDTH-1:0]   vq_scalar,
  input  logic                    vq_ready,
  output logic [ADDR_BITS:0]      vq_count
);

  vec_class_e                  cls;
  logic                        is_vec;
  logic                        needs_scalar;
  logic                        push;
  logic                        pop;
  logic                        full;
  logic                        empty;
  logic [WORD_WIDTH-1:0]       scalar_sel;
  logic [2*WORD_WIDTH-1:0]     wr_data;
  logic [2*WORD_WIDTH-1:0]     rd_data;

  assign cls          = classify(instr[6:0], instr[14:12]);
  assign is_vec       = (cls != VCLS_NONE);
  assign needs_scalar = (cls == VCLS_SCALAR);

  // rs1 is read unconditionally; the mux decides whether the value is kept.
  assign v_rd_xreg_addr = instr[15 +: REGFILE_BITS];
  assign scalar_sel     = needs_scalar ? xreg_out : '0;

  assign instr_ready = ~full;
  assign push        = instr_valid & instr_ready & is_vec & ~flush;
  assign pop         = vq_valid & vq_ready & ~flush;
  assign wr_data     = {instr, scalar_sel};

  vq_fifo #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS),
    .DATA_W    (2*WORD_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .flush   (flush),
    .wr_en   (push),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (vq_count)
  );

  assign vq_valid  = ~empty;
  assign vq_instr  = rd_data[2*WORD_WIDTH-1:WORD_WIDTH];
  assign vq_scalar = rd_data[WORD_WIDTH-1:0];

endmodule

// File: tb/tb_vec_instr_queue.sv
// Directed bench for vec_instr_queue: hand-computed expectations checked with immediate assertions.
module tb_vec_instr_queue;

  logic        clk;
  logic        nrst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  v_rd_xreg_addr;
  logic [31:0] xreg_out;
  logic        flush;
  logic        vq_valid;
  logic [31:0] vq_instr;
  logic [31:0] vq_scalar;
  logic        vq_ready;
  logic [2:0]  vq_count;

  int errors = 0;
  int checks = 0;

  vec_instr_queue dut (
    .clk            (clk),
    .nrst           (nrst),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_ready    (instr_ready),
    .v_rd_xreg_addr (v_rd_xreg_addr),
    .xreg_out       (xreg_out),
    .flush          (flush),
    .vq_valid       (vq_valid),
    .vq_instr       (vq_instr),
    .vq_scalar      (vq_scalar),
    .vq_ready       (vq_ready),
    .vq_count       (vq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] x,
                       input logic rdy, input logic fl);
    instr_valid = v;
    instr       = i;
    xreg_out    = x;
    vq_ready    = rdy;
    flush       = fl;
  endtask

  // Each call advances exactly one clock; inputs change and are sampled mid-low-phase.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] wrap_instr(input int k);
    logic [31:0] w;
    w = 32'h0200_0057 | (32'(k) << 7);
    if (k % 2 == 1) w = w | 32'h0000_4000;
    return w;
  endfunction

  function automatic logic [31:0] wrap_scalar(input int k);
    return (k % 2 == 1) ? (32'hC0DE_0000 + 32'(k)) : 32'h0;
  endfunction

  initial begin
    int wr_i;
    int rd_i;
    int cyc;
    logic tog;
    logic acc;
    logic popd;

    nrst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("rst_valid", {63'd0, vq_valid}, 64'd0);
    chk("rst_count", {61'd0, vq_count}, 64'd0);
    chk("rst_ready", {63'd0, instr_ready}, 64'd1);
    chk("rst_instr", {32'd0, vq_instr}, 64'd0);
    chk("rst_scalar", {32'd0, vq_scalar}, 64'd0);

    // vadd.vx, rs1 = x5
    drive(1'b1, 32'h0222_C0D7, 32'hDEAD_BEEF, 1'b0, 1'b0);
    #1;
    chk("vx_xaddr", {59'd0, v_rd_xreg_addr}, 64'd5);
    chk("vx_no_bypass", {63'd0, vq_valid}, 64'd0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("vx_valid", {63'd0, vq_valid}, 64'd1);
    chk("vx_instr", {32'd0, vq_instr}, 64'h0222_C0D7);
    chk("vx_scalar", {32'd0, vq_scalar}, 64'hDEAD_BEEF);
    chk("vx_count", {61'd0, vq_count}, 64'd1);

    // vadd.vv pushed while head is popped
    drive(1'b1, 32'h0222_80D7, 32'h1234_5678, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("vv_count", {61'd0, vq_count}, 64'd1);
    chk("vv_instr", {32'd0, vq_instr}, 64'h0222_80D7);
    chk("vv_scalar", {32'd0, vq_scalar}, 64'd0);

    // addi is not a vector instruction
    drive(1'b1, 32'h0050_0093, 32'hFFFF_FFFF, 1'b0, 1'b0);
    #1;
    chk("addi_ready", {63'd0, instr_ready}, 64'd1);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("addi_count", {61'd0, vq_count}, 64'd1);
    chk("addi_head", {32'd0, vq_instr}, 64'h0222_80D7);

    // Fill: LOAD-FP, STORE-FP, OPMVX
    drive(1'b1, 32'h0205_6087, 32'hA5A5_A5A5, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 32'h0205_60A7, 32'h5A5A_5A5A, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 32'h0222_E0D7, 32'h1111_2222, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("full_count", {61'd0, vq_count}, 64'd4);
    chk("full_ready", {63'd0, instr_ready}, 64'd0);

    // 5th instruction with a pop while full: rejected
    drive(1'b1, 32'h0222_C157, 32'h3333_4444, 1'b1, 1'b0);
    next_cycle();
    chk("full_pop_count", {61'd0, vq_count}, 64'd3);
    chk("full_pop_head", {32'd0, vq_instr}, 64'h0205_6087);
    drive(1'b1, 32'h0222_C157, 32'h3333_4444, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("retry_count", {61'd0, vq_count}, 64'd4);

    chk("drain0_instr", {32'd0, vq_instr}, 64'h0205_6087);
    chk("drain0_scalar", {32'd0, vq_scalar}, 64'hA5A5_A5A5);
    next_cycle();
    chk("drain1_instr", {32'd0, vq_instr}, 64'h0205_60A7);
    chk("drain1_scalar", {32'd0, vq_scalar}, 64'h5A5A_5A5A);
    next_cycle();
    chk("drain2_instr", {32'd0, vq_instr}, 64'h0222_E0D7);
    chk("drain2_scalar", {32'd0, vq_scalar}, 64'h1111_2222);
    next_cycle();
    chk("drain3_instr", {32'd0, vq_instr}, 64'h0222_C157);
    chk("drain3_scalar", {32'd0, vq_scalar}, 64'h3333_4444);
    next_cycle();
    chk("empty_valid", {63'd0, vq_valid}, 64'd0);
    chk("empty_instr", {32'd0, vq_instr}, 64'd0);
    next_cycle();
    chk("empty_pop_ignored", {61'd0, vq_count}, 64'd0);

    // Wrap-around stream with vq_ready toggling
    wr_i = 0;
    rd_i = 0;
    cyc  = 0;
    tog  = 1'b1;
    while ((wr_i < 10 || rd_i < 10) && cyc < 200) begin
      drive(wr_i < 10, wrap_instr(wr_i), wrap_scalar(wr_i), tog, 1'b0);
      #1;
      acc  = instr_valid & instr_ready;
      popd = vq_valid & vq_ready;
      if (popd) begin
        chk("wrap_instr", {32'd0, vq_instr}, {32'd0, wrap_instr(rd_i)});
        chk("wrap_scalar", {32'd0, vq_scalar}, {32'd0, wrap_scalar(rd_i)});
      end
      next_cycle();
      if (acc) wr_i++;
      if (popd) rd_i++;
      tog = ~tog;
      cyc++;
    end
    chk("wrap_pushed", 64'(wr_i), 64'd10);
    chk("wrap_popped", 64'(rd_i), 64'd10);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("wrap_count", {61'd0, vq_count}, 64'd0);

    // Flush priority over push and pop
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, wrap_instr(k), 32'h0, 1'b0, 1'b0);
      next_cycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("pre_flush_count", {61'd0, vq_count}, 64'd3);
    drive(1'b1, 32'h0222_C0D7, 32'h7777_7777, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("flush_count", {61'd0, vq_count}, 64'd0);
    chk("flush_valid", {63'd0, vq_valid}, 64'd0);
    drive(1'b1, 32'h0222_80D7, 32'h0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("post_flush_count", {61'd0, vq_count}, 64'd1);
    chk("post_flush_head", {32'd0, vq_instr}, 64'h0222_80D7);

    // Reset mid-operation discards entries
    nrst = 1'b0;
    next_cycle();
    nrst = 1'b1;
    #1;
    chk("midrst_count", {61'd0, vq_count}, 64'd0);
    chk("midrst_valid", {63'd0, vq_valid}, 64'd0);
    chk("midrst_ready", {63'd0, instr_ready}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
